playfield_gen: RTL and testbench

- Parametrised successor to the fixed 22-bit playfield renderer in the peripherals block.
- Turns CPU-written playfield bits and colour registers into per-pixel RGB, driven by the HDMI timing counters (hpos, in_hblank, in_vblank).
- Adds configurable bit count and pixels-per-bit, mirror/repeat modes, a border, and vblank-synchronised double buffering.
- Sits between the peripheral register decode and the hdmi instance.

---
 rtl/playfield_gen.sv | 162 ++++++++++++++++
 tb/tb_playfield_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/playfield_gen.sv
// Playfield renderer: CPU-written playfield bits and colour registers to per-pixel RGB, double-buffered on vblank.
// Optional score mode (fg2 colour for the second half-line) is enabled by defining PLAYFIELD_SCORE_EN.
module playfield_gen #(
  parameter int PF_BITS   = 22,
  parameter int BIT_SHIFT = 4,
  parameter int H_START   = 96,
  parameter int BORDER_PX = 8
) (
  input  logic       raw_clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [9:0] hpos,
  input  logic       in_hblank,
  input  logic       in_vblank,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       line_done
);
`ifdef PLAYFIELD_SCORE_EN
  localparam int NREG = 17;
`else
  localparam int NREG = 14;
`endif
  localparam int BW = $clog2(BORDER_PX + 1);
  localparam logic [BW-1:0]        BRD_LAST = BW'(BORDER_PX - 1);
  localparam logic [BIT_SHIFT-1:0] PIX_LAST = '1;
  localparam logic [4:0]           BIT_LAST = 5'(PF_BITS - 1);
  localparam logic [9:0]           H_TRIG   = 10'(H_START - BORDER_PX);
  localparam logic [31:0]          PF_MASK  = (PF_BITS >= 32) ? 32'hFFFF_FFFF :
                                              32'((64'd1 << PF_BITS) - 64'd1);

  typedef enum logic [2:0] {IDLE, LBORDER, FIRST, SECOND, RBORDER, DONE} state_t;

  function automatic logic [7:0] rst_val(input int i);
    case (i)
      5, 10, 15: rst_val = 8'hFF;  // fg red, bg blue, fg2 green
      default:   rst_val = 8'h00;
    endcase
  endfunction

  logic [7:0]           sh_q  [NREG];
  logic [7:0]           sh_d  [NREG];
  logic [7:0]           act_q [NREG];
  logic [7:0]           act_d [NREG];
  logic                 vblank_q;
  logic                 commit;
  state_t               state_q, state_d;
  logic [BIT_SHIFT-1:0] pix_q, pix_d;
  logic [4:0]           bit_q, bit_d;
  logic [BW-1:0]        brd_q, brd_d;
  logic [23:0]          rgb_q, rgb_d;
  logic                 done_q, done_d;

  // Register file: shadow always takes the write; active follows on commit, or at once for ctrl/immediate.
  always_comb begin
    commit = in_vblank & ~vblank_q;
    for (int i = 0; i < NREG; i++) begin
      sh_d[i]  = sh_q[i];
      act_d[i] = commit ? sh_q[i] : act_q[i];
      if (wr_en && wr_addr == 5'(i)) begin
        sh_d[i] = wr_data;
        if (act_q[4][1] || i == 4) act_d[i] = wr_data;
      end
    end
  end

  // State and counters describe the pixel at the hpos being sampled this cycle.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    bit_d   = bit_q;
    brd_d   = brd_q;
    if (in_hblank) begin
      state_d = IDLE;
      pix_d   = '0;
      bit_d   = '0;
      brd_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (hpos == H_TRIG) begin
          state_d = LBORDER;
          brd_d   = '0;
        end
        LBORDER, RBORDER: if (brd_q == BRD_LAST) begin
          state_d = (state_q == LBORDER) ? FIRST : DONE;
          pix_d   = '0;
          bit_d   = '0;
          brd_d   = '0;
        end else begin
          brd_d = brd_q + 1'b1;
        end
        FIRST, SECOND: if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            brd_d   = '0;
            state_d = (state_q == FIRST) ? SECOND : RBORDER;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  logic [31:0] pf;
  logic [4:0]  idx;
  logic [23:0] fg_c;

  always_comb begin
    pf  = {act_q[3], act_q[2], act_q[1], act_q[0]} & PF_MASK;
    idx = (state_d == SECOND && act_q[4][0]) ? bit_d : BIT_LAST - bit_d;
`ifdef PLAYFIELD_SCORE_EN
    fg_c = (state_d == SECOND && act_q[4][2]) ? {act_q[14], act_q[15], act_q[16]}
                                              : {act_q[5], act_q[6], act_q[7]};
`else
    fg_c = {act_q[5], act_q[6], act_q[7]};
`endif
    done_d = (state_d == RBORDER) && (state_q != RBORDER);
    if (in_hblank || in_vblank)
      rgb_d = '0;
    else if (state_d == FIRST || state_d == SECOND)
      rgb_d = pf[idx] ? fg_c : {act_q[8], act_q[9], act_q[10]};
    else
      rgb_d = {act_q[11], act_q[12], act_q[13]};
  end

  always_ff @(posedge raw_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        sh_q[i]  <= rst_val(i);
        act_q[i] <= rst_val(i);
      end
      vblank_q <= 1'b0;
      state_q  <= IDLE;
      pix_q    <= '0;
      bit_q    <= '0;
      brd_q    <= '0;
      rgb_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      sh_q     <= sh_d;
      act_q    <= act_d;
      vblank_q <= in_vblank;
      state_q  <= state_d;
      pix_q    <= pix_d;
      bit_q    <= bit_d;
      brd_q    <= brd_d;
      rgb_q    <= rgb_d;
      done_q   <= done_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign line_done          = done_q;
endmodule

// File: tb/tb_playfield_gen.sv
// Bench for playfield_gen: default instance plus a PF_BITS=8/BIT_SHIFT=3 instance on shared stimulus,
// checked against a per-pixel scoreboard derived from scan geometry.
module tb_playfield_gen;
  logic       raw_clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [9:0] hpos = '0;
  logic       in_hblank = 1'b1;
  logic       in_vblank = 1'b0;
  logic [7:0] r1, g1, b1, r2, g2, b2;
  logic       ld1, ld2;

  always #5 raw_clk = ~raw_clk;

  playfield_gen dut (
    .raw_clk(raw_clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hpos(hpos), .in_hblank(in_hblank), .in_vblank(in_vblank),
    .red(r1), .green(g1), .blue(b1), .line_done(ld1));

  playfield_gen #(.PF_BITS(8), .BIT_SHIFT(3)) dut2 (
    .raw_clk(raw_clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hpos(hpos), .in_hblank(in_hblank), .in_vblank(in_vblank),
    .red(r2), .green(g2), .blue(b2), .line_done(ld2));

  typedef struct {string tag; int h; logic [23:0] rgb1; logic ld1; logic [23:0] rgb2; logic ld2;} exp_t;
  typedef struct {logic [4:0] a; logic [7:0] d;} wr_t;

  exp_t       sb[$];
  wr_t        pend[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] sh[14];
  logic [7:0] ac[14];
  bit         vb_prev;
  string      phase = "reset";

  task automatic chk(input string tag, input int h, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s h=%0d got=%h exp=%h", tag, h, obs, exp);
    end
  endtask

  always begin
    @(posedge raw_clk);
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk({mon_e.tag, "_rgb"},   mon_e.h, {8'h0, r1, g1, b1}, {8'h0, mon_e.rgb1});
      chk({mon_e.tag, "_ld"},    mon_e.h, {31'h0, ld1},       {31'h0, mon_e.ld1});
      chk({mon_e.tag, "_rgb_8"}, mon_e.h, {8'h0, r2, g2, b2}, {8'h0, mon_e.rgb2});
      chk({mon_e.tag, "_ld_8"},  mon_e.h, {31'h0, ld2},       {31'h0, mon_e.ld2});
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < 14; i++) begin
      sh[i] = (i == 5 || i == 10) ? 8'hFF : 8'h00;
      ac[i] = sh[i];
    end
    vb_prev = 1'b0;
  endfunction

  // Expected pixel from scan geometry: scan starts at hpos 96, each half-line is pfb bits of 2^bs pixels.
  function automatic logic [23:0] exp_rgb(input int h, input bit hb, input bit vb, input int pfb, input int bs);
    int w, off, b, idx;
    logic [31:0] pfv;
    if (hb || vb) return 24'h0;
    w = (2 * pfb) << bs;
    if (h < 96 || h >= 96 + w) return {ac[11], ac[12], ac[13]};
    off = h - 96;
    b   = (off >> bs) % pfb;
    pfv = {ac[3], ac[2], ac[1], ac[0]};
    idx = (off >= (pfb << bs) && ac[4][0]) ? b : pfb - 1 - b;
    return pfv[idx] ? {ac[5], ac[6], ac[7]} : {ac[8], ac[9], ac[10]};
  endfunction

  task automatic cyc(input int h, input bit hb, input bit vb,
                     input bit we = 1'b0, input logic [4:0] a = 5'h0, input logic [7:0] d = 8'h0);
    exp_t e;
    @(negedge raw_clk);
    hpos = 10'(h); in_hblank = hb; in_vblank = vb;
    wr_en = we; wr_addr = a; wr_data = d;
    e.tag  = phase;
    e.h    = h;
    e.rgb1 = exp_rgb(h, hb, vb, 22, 4);
    e.ld1  = !hb && h == 96 + 704;
    e.rgb2 = exp_rgb(h, hb, vb, 8, 3);
    e.ld2  = !hb && h == 96 + 128;
    sb.push_back(e);
    if (vb && !vb_prev)
      for (int i = 0; i < 14; i++) ac[i] = sh[i];
    vb_prev = vb;
    if (we && a < 5'd14) begin
      sh[a] = d;
      if (ac[4][1] || a == 5'd4) ac[a] = d;
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1000, 1'b1, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cyc(1000, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic vsync(input bit we = 1'b0, input logic [4:0] a = 5'h0, input logic [7:0] d = 8'h0);
    cyc(1000, 1'b1, 1'b1, we, a, d);
    cyc(1000, 1'b1, 1'b1);
    cyc(1000, 1'b1, 1'b0);
  endtask

  // One line from hpos 0; queued writes go out on consecutive cycles from hpos wh.
  task automatic line(input int wh, input int last);
    wr_t w;
    blank(2);
    for (int h = 0; h <= last; h++) begin
      if (wh >= 0 && h >= wh && pend.size() != 0) begin
        w = pend.pop_front();
        cyc(h, 1'b0, 1'b0, 1'b1, w.a, w.d);
      end else begin
        cyc(h, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge raw_clk);
    chk("rst_rgb", 0, {8'h0, r1, g1, b1}, 32'h0);
    chk("rst_ld", 0, {31'h0, ld1}, 32'h0);
    chk("rst_rgb_8", 0, {8'h0, r2, g2, b2}, 32'h0);
    reset = 1'b1;

    phase = "defaults";
    wr(5'd0, 8'h01); wr(5'd1, 8'h00); wr(5'd2, 8'h20); wr(5'd3, 8'h00);
    line(-1, 815);                         // shadow only: scan still all bg
    vsync();
    line(-1, 815);

    phase = "mirror";
    wr(5'd4, 8'h01); wr(5'd0, 8'h01); wr(5'd2, 8'h00); wr(5'd11, 8'h55);
    vsync();
    line(-1, 815);

    phase = "dbuf";
    wr(5'd4, 8'h00);
    pend.push_back('{5'd5, 8'h00});
    pend.push_back('{5'd6, 8'hFF});
    line(300, 815);
    vsync(1'b1, 5'd7, 8'h40);              // write lands in shadow only
    line(-1, 815);
    vsync();
    line(-1, 815);

    phase = "immediate";
    wr(5'd4, 8'h02);
    wr(5'd0, 8'h80);
    pend.push_back('{5'd8, 8'h11});
    pend.push_back('{5'd9, 8'h22});
    pend.push_back('{5'd10, 8'h33});
    line(200, 815);

    phase = "midreset";
    line(-1, 299);
    @(negedge raw_clk);
    wr_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("async_rst_rgb", 300, {8'h0, r1, g1, b1}, 32'h0);
    chk("async_rst_rgb_8", 300, {8'h0, r2, g2, b2}, 32'h0);
    chk("async_rst_ld", 300, {31'h0, ld1}, 32'h0);
    repeat (3) @(negedge raw_clk);
    in_hblank = 1'b1;
    model_reset();
    reset = 1'b1;
    phase = "after_reset";
    line(-1, 815);

    repeat (3) @(negedge raw_clk);
    chk("sb_drained", 0, sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
